// File: rtl/mcp_pkg.sv
// Shared types for the multi-channel multi-cycle-path capture block.
// Handshake mode selector and per-channel FSM state encoding.
package mcp_pkg;

    typedef enum logic {
        MCP_LEVEL  = 1'b0,
        MCP_TOGGLE = 1'b1
    } mcp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ACK  = 2'd2
    } mcp_state_e;

endpackage

// File: rtl/mcp_capture_multi_if.sv
// Launch/consumer-side bundle for N channels of W-bit captured data.
// master = launch domain + consumer, slave = capture logic.
interface mcp_capture_multi_if #(
    parameter int W = 32,
    parameter int N = 4
);
    logic [N*W-1:0] l_dat;
    logic [N-1:0]   l_vld;
    logic [N-1:0]   ack;
    logic [N-1:0]   out_vld;
    logic [N-1:0]   out_rdy;
    logic [N*W-1:0] out_dat;

    modport master (
        output l_dat, l_vld, out_rdy,
        input  ack, out_vld, out_dat
    );

    modport slave (
        input  l_dat, l_vld, out_rdy,
        output ack, out_vld, out_dat
    );
endinterface

// File: rtl/mcp_capture_chan.sv
// One capture channel: request synchroniser, IDLE/HOLD/ACK FSM, data register.
// Valid rises SYNC_STAGES+1 edges after the request; holds until out_rdy.
module mcp_capture_chan
    import mcp_pkg::*;
#(
    parameter int        W           = 32,
    parameter int        SYNC_STAGES = 2,
    parameter mcp_mode_e MODE        = MCP_LEVEL
) (
    input  logic                c_clk,
    input  logic                c_rst,
    mcp_capture_multi_if.slave  bus
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;
    logic                   w_new_req;
    mcp_state_e             r_state;
    logic                   r_last;
    logic                   r_ack;
    logic                   r_vld;
    logic [W-1:0]           r_dat;

    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], bus.l_vld[0]};
    end

    assign w_req_s   = r_sync[SYNC_STAGES-1];
    assign w_new_req = (MODE == MCP_TOGGLE) ? (w_req_s != r_last) : w_req_s;

    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_vld   <= 1'b0;
            r_dat   <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_new_req) begin
                        r_dat   <= bus.l_dat;
                        r_vld   <= 1'b1;
                        r_state <= ST_HOLD;
                        if (MODE == MCP_TOGGLE) r_last <= w_req_s;
                    end
                end
                ST_HOLD: begin
                    // Ack is raised (or flipped) on the acceptance edge itself.
                    if (bus.out_rdy[0]) begin
                        r_vld   <= 1'b0;
                        r_state <= ST_ACK;
                        r_ack   <= (MODE == MCP_TOGGLE) ? ~r_ack : 1'b1;
                    end
                end
                ST_ACK: begin
                    if (MODE == MCP_TOGGLE) begin
                        r_state <= ST_IDLE;
                    end else if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack[0]     = r_ack;
    assign bus.out_vld[0] = r_vld;
    assign bus.out_dat    = r_dat;

`ifndef SYNTHESIS
    // The launch side must not move its request while this channel is busy.
    always @(posedge c_clk) begin
        if (!c_rst) begin
            if (MODE == MCP_TOGGLE && r_state != ST_IDLE)
                assert (w_req_s == r_last) else $error("mcp_capture_chan: toggle request changed while busy");
            if (MODE == MCP_LEVEL && r_state == ST_HOLD)
                assert (w_req_s) else $error("mcp_capture_chan: level request dropped before acknowledge");
        end
    end
`endif

endmodule

// File: rtl/mcp_capture_multi.sv
// N independent multi-cycle-path capture channels sharing one capture clock.
// Per channel: valid SYNC_STAGES+1 edges after request; holds data under backpressure.
module mcp_capture_multi
    import mcp_pkg::*;
#(
    parameter int        W           = 32,
    parameter int        N           = 4,
    parameter int        SYNC_STAGES = 2,
    parameter mcp_mode_e MODE        = MCP_LEVEL
) (
    input  logic         c_clk,
    input  logic         c_rst,
    input  logic [N*W-1:0] sync_l_out_r,
    input  logic [N-1:0]   sync_l_out_valid_r,
    output logic [N-1:0]   sync_c_ack_r,
    output logic [N-1:0]   c_out_valid_r,
    input  logic [N-1:0]   c_out_ready,
    output logic [N*W-1:0] c_out_r
);

    if (SYNC_STAGES < 2 || N < 1 || W < 1) begin : g_bad_param
        $error("mcp_capture_multi: need SYNC_STAGES>=2, N>=1, W>=1");
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        mcp_capture_multi_if #(.W(W), .N(1)) w_ch ();

        assign w_ch.l_dat   = sync_l_out_r[i*W +: W];
        assign w_ch.l_vld   = sync_l_out_valid_r[i];
        assign w_ch.out_rdy = c_out_ready[i];

        assign sync_c_ack_r[i]   = w_ch.ack[0];
        assign c_out_valid_r[i]  = w_ch.out_vld[0];
        assign c_out_r[i*W +: W] = w_ch.out_dat;

        mcp_capture_chan #(
            .W           (W),
            .SYNC_STAGES (SYNC_STAGES),
            .MODE        (MODE)
        ) u_chan (
            .c_clk (c_clk),
            .c_rst (c_rst),
            .bus   (w_ch.slave)
        );
    end

endmodule

// File: doc/mcp_capture_multi.md
MCP_CAPTURE_MULTI -- requirements
Module: mcp_capture_multi

Interface
REQ-001 SHALL have parameter W, default 32: data width per channel, >=1.
REQ-002 SHALL have parameter N, default 4: number of independent channels, >=1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, >=2.
REQ-004 SHALL have parameter MODE, default MCP_LEVEL: MCP_LEVEL is a 4-phase level handshake; MCP_TOGGLE is a 2-phase toggle handshake.
REQ-005 SHALL have port c_clk, input, 1 bit: capture-domain clock, the only clock.
REQ-006 SHALL have port c_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port sync_l_out_r, input, N*W bits: launch-domain data; channel i occupies bits [i*W +: W] and is stable while its request is pending.
REQ-008 SHALL have port sync_l_out_valid_r, input, N bits: launch-domain request per channel, a level in MCP_LEVEL mode and a toggle in MCP_TOGGLE mode.
REQ-009 SHALL have port sync_c_ack_r, output, N bits: registered acknowledge to the launch domain, a level or a toggle per MODE.
REQ-010 SHALL have port c_out_valid_r, output, N bits: registered flag per channel, high while captured data awaits the consumer.
REQ-011 SHALL have port c_out_ready, input, N bits: consumer accepts channel i when c_out_valid_r[i] and c_out_ready[i] are both high.
REQ-012 SHALL have port c_out_r, output, N*W bits: captured data per channel, registered.

Function
REQ-013 SHALL pass each sync_l_out_valid_r bit through its own SYNC_STAGES-flop synchroniser; the synchronised output is req_s[i].
REQ-014 SHALL run a per-channel FSM with states IDLE, HOLD and ACK; channels share no state.
REQ-015 SHALL detect a new request in IDLE as follows: in MCP_LEVEL mode, req_s[i] high; in MCP_TOGGLE mode, req_s[i] differs from a last-seen toggle register.
REQ-016 SHALL, on detection in IDLE, load c_out_r[i] from sync_l_out_r[i], set c_out_valid_r[i], enter HOLD, and (toggle mode only) update the last-seen toggle, all at one edge.
REQ-017 SHALL set c_out_valid_r[i] high at clock edge SYNC_STAGES+1 after the first edge that samples a request change, given the FSM is in IDLE.
REQ-018 SHALL in HOLD keep c_out_r[i] and c_out_valid_r[i] stable until c_out_ready[i]; on acceptance, clear c_out_valid_r[i] and enter ACK at the same edge.
REQ-019 SHALL, in MCP_TOGGLE mode on entry to ACK, invert sync_c_ack_r[i] and return to IDLE one edge later.
REQ-020 SHALL, in MCP_LEVEL mode in ACK, drive sync_c_ack_r[i] high; once req_s[i] is seen low, clear sync_c_ack_r[i] and enter IDLE at that edge.
REQ-021 SHALL, in MCP_LEVEL mode, not re-detect a request in the edge immediately after leaving ACK unless req_s[i] is high again.
REQ-022 SHALL allow c_out_ready[i] to be high before c_out_valid_r[i] is set; this does not cause a zero-cycle pass-through.
REQ-023 SHALL ignore request changes arriving in HOLD or ACK; the protocol forbids them and they raise a simulation assertion.
REQ-024 SHALL sustain one transfer per channel per handshake round trip; throughput is limited only by synchroniser latency and consumer backpressure.

Reset
REQ-025 SHALL, on c_rst asserted, immediately force these values in every channel: FSM to IDLE; sync_c_ack_r, c_out_valid_r and c_out_r to 0; synchroniser flops and last-seen toggles to 0.
REQ-026 SHALL, on reset mid-operation, abandon the in-flight transfer; the launch domain is required to be reset concurrently.
REQ-027 SHALL release reset synchronously to c_clk, via an external reset synchroniser.

Structure
REQ-028 SHALL put the mode typedef (MCP_LEVEL/MCP_TOGGLE) and the FSM state enum in shared package mcp_pkg.
REQ-029 SHALL implement one channel in sub-module mcp_capture_chan (synchroniser + FSM + data register), instantiated N times by a generate loop.
REQ-030 SHALL check at elaboration that SYNC_STAGES>=2, N>=1 and W>=1.

Verification
REQ-031 SHALL cover single level transfer: W=32, SYNC_STAGES=2, level mode, data 0xDEADBEEF, valid rises, ready held high -> c_out_valid_r high at edge 3, c_out_r=0xDEADBEEF, one-cycle pulse, ack rises next edge, ack falls after the synchronised valid drops.
REQ-032 SHALL cover backpressure: ready held low for 10 cycles -> c_out_valid_r and c_out_r stable for 10 cycles, ack stays 0 until acceptance.
REQ-033 SHALL cover toggle mode: 3 back-to-back transfers 0x1, 0x2, 0x3 -> 3 accepts in order, sync_c_ack_r toggles 0->1->0->1, no duplicate capture.
REQ-034 SHALL cover channel independence: N=4, channels 0 and 3 request on the same edge, channel 3 ready low -> channel 0 completes its full handshake while channel 3 holds.
REQ-035 SHALL cover reset mid-operation: c_rst asserted while in HOLD -> all outputs 0 with no clock edge; after release, a new transfer 0x55 completes normally.
REQ-036 SHALL cover depth: SYNC_STAGES=3 -> c_out_valid_r high at edge 4 after the request.
